// File: rtl/viterbi_acs.sv
// Add-compare-select unit for a rate 1/2, K=3 (7,5 octal) Viterbi decoder.
// Updates the four path metrics once per accepted hard-decision symbol and
// presents survivor bits, metrics, best state and normalization flag through
// a valid/ready output stage with single-cycle latency.
module viterbi_acs #(
    parameter int PM_W    = 8,
    parameter int INIT_PM = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      rx_sym,
    input  logic            frame_start,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      surv,
    output logic [PM_W-1:0] pm0,
    output logic [PM_W-1:0] pm1,
    output logic [PM_W-1:0] pm2,
    output logic [PM_W-1:0] pm3,
    output logic [1:0]      best_state,
    output logic            norm
);

    localparam logic [PM_W-1:0] INIT_V   = PM_W'(INIT_PM);
    // Bit PM_W-1 of the candidate width; cleared in all states on normalization.
    localparam logic [PM_W:0]   MSB_MASK = (PM_W+1)'(1) << (PM_W - 1);

    logic [PM_W-1:0] pm_q     [4];
    logic [PM_W-1:0] src      [4];
    logic [PM_W:0]   cand     [4][2];
    logic [PM_W:0]   sel_pm   [4];
    logic [PM_W:0]   norm_pm  [4];
    logic [3:0]      new_surv;
    logic            new_norm;
    logic [1:0]      new_best;
    logic [PM_W:0]   min_pm;
    logic            accept;

    // Hamming distance between the received pair and the branch code of the
    // transition from predecessor {n[0], x} into state n.
    function automatic logic [1:0] branch_metric(input logic [1:0] rx,
                                                 input logic [1:0] n,
                                                 input logic       x);
        logic c0;
        logic c1;
        c0 = n[1] ^ n[0] ^ x;
        c1 = n[1] ^ x;
        return {1'b0, rx[1] ^ c0} + {1'b0, rx[0] ^ c1};
    endfunction

    assign in_ready = out_ready | ~out_valid;
    assign accept   = in_valid & in_ready;

    assign pm0 = pm_q[0];
    assign pm1 = pm_q[1];
    assign pm2 = pm_q[2];
    assign pm3 = pm_q[3];

    // Source metrics: stored values, or the frame-start seed values.
    always_comb begin
        for (int p = 0; p < 4; p++) begin
            if (frame_start)
                src[p] = (p == 0) ? '0 : INIT_V;
            else
                src[p] = pm_q[p];
        end
    end

    // Add-compare-select per state; ties keep the x=0 predecessor.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            for (int x = 0; x < 2; x++) begin
                cand[n][x] = {1'b0, src[{n[0], x[0]}]}
                           + (PM_W+1)'(branch_metric(rx_sym, 2'(n), x[0]));
            end
            new_surv[n] = (cand[n][1] < cand[n][0]);
            sel_pm[n]   = new_surv[n] ? cand[n][1] : cand[n][0];
        end
    end

    // Normalization and minimum-metric search on the normalized values.
    always_comb begin
        new_norm = 1'b1;
        for (int n = 0; n < 4; n++)
            new_norm = new_norm & sel_pm[n][PM_W-1];
        for (int n = 0; n < 4; n++)
            norm_pm[n] = new_norm ? (sel_pm[n] & ~MSB_MASK) : sel_pm[n];
        new_best = 2'd0;
        min_pm   = norm_pm[0];
        for (int n = 1; n < 4; n++) begin
            if (norm_pm[n] < min_pm) begin
                min_pm   = norm_pm[n];
                new_best = 2'(n);
            end
        end
    end

    // Result and metric registers: load on acceptance, hold under backpressure.
    // NOTE: the metric array is only four words, so it is reset like any register.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            surv       <= '0;
            best_state <= '0;
            norm       <= 1'b0;
            pm_q[0]    <= '0;
            for (int n = 1; n < 4; n++)
                pm_q[n] <= INIT_V;
        end else if (accept) begin
            out_valid  <= 1'b1;
            surv       <= new_surv;
            best_state <= new_best;
            norm       <= new_norm;
            for (int n = 0; n < 4; n++)
                pm_q[n] <= norm_pm[n][PM_W-1:0];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_viterbi_acs.sv
// Self-checking bench for viterbi_acs: directed steps, a scoreboard queue of
// expected results, and an unbounded-width metric reference.
module tb_viterbi_acs;

    localparam int PM_W    = 8;
    localparam int INIT_PM = 32;

    typedef struct {
        logic [3:0] surv;
        int         pm [4];
        logic [1:0] best;
        logic       norm;
    } res_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      rx_sym;
    logic            frame_start;
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      surv;
    logic [PM_W-1:0] pm0, pm1, pm2, pm3;
    logic [1:0]      best_state;
    logic            norm;

    res_t   sb [$];
    bit     mdl_ov;
    int     mdl_pm [4];
    longint ref_u  [4];
    int     n_checks;
    int     n_fails;

    viterbi_acs #(.PM_W(PM_W), .INIT_PM(INIT_PM)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .rx_sym(rx_sym), .frame_start(frame_start), .out_valid(out_valid),
        .out_ready(out_ready), .surv(surv), .pm0(pm0), .pm1(pm1), .pm2(pm2),
        .pm3(pm3), .best_state(best_state), .norm(norm)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // Reference ACS: bounded metrics with normalization, plus an unbounded copy.
    function automatic void model_acs(input logic [1:0] rx, input bit fs, output res_t r);
        int     src [4];
        longint usrc [4];
        int     nw [4];
        longint unw [4];
        int     best_v;
        for (int p = 0; p < 4; p++) begin
            src[p]  = fs ? ((p == 0) ? 0 : INIT_PM) : mdl_pm[p];
            usrc[p] = fs ? ((p == 0) ? 0 : INIT_PM) : ref_u[p];
        end
        for (int n = 0; n < 4; n++) begin
            int c [2];
            longint uc [2];
            for (int x = 0; x < 2; x++) begin
                int p, u, c0, c1, bm;
                p  = ((n & 1) << 1) | x;
                u  = (n >> 1) & 1;
                c0 = u ^ (n & 1) ^ x;
                c1 = u ^ x;
                bm = (((rx >> 1) & 1) ^ c0) + ((rx & 1) ^ c1);
                c[x]  = src[p] + bm;
                uc[x] = usrc[p] + bm;
            end
            r.surv[n] = (c[1] < c[0]);
            nw[n]  = (c[1] < c[0]) ? c[1] : c[0];
            unw[n] = (uc[1] < uc[0]) ? uc[1] : uc[0];
        end
        r.norm = (nw[0] >= 128) && (nw[1] >= 128) && (nw[2] >= 128) && (nw[3] >= 128);
        best_v = 0;
        for (int n = 0; n < 4; n++) begin
            if (r.norm) nw[n] = nw[n] - (1 << (PM_W - 1));
            r.pm[n]   = nw[n];
            mdl_pm[n] = nw[n];
            ref_u[n]  = unw[n];
        end
        for (int n = 1; n < 4; n++)
            if (nw[n] < nw[best_v]) best_v = n;
        r.best = 2'(best_v);
    endfunction

    task automatic compare_front();
        res_t r;
        r = sb[0];
        check("surv", 64'(surv), 64'(r.surv));
        check("pm0", 64'(pm0), 64'(r.pm[0]));
        check("pm1", 64'(pm1), 64'(r.pm[1]));
        check("pm2", 64'(pm2), 64'(r.pm[2]));
        check("pm3", 64'(pm3), 64'(r.pm[3]));
        check("best_state", 64'(best_state), 64'(r.best));
        check("norm", 64'(norm), 64'(r.norm));
    endtask

    // One clock cycle: drive at the falling edge, sample at the next one.
    task automatic cycle(input bit v, input logic [1:0] sym, input bit fs, input bit ordy);
        bit   exp_ir;
        res_t r;
        in_valid    = v;
        rx_sym      = sym;
        frame_start = fs;
        out_ready   = ordy;
        #1;
        exp_ir = ordy || !mdl_ov;
        check("in_ready", 64'(in_ready), 64'(exp_ir));
        if (mdl_ov && ordy && sb.size() > 0) r = sb.pop_front();
        if (v && exp_ir) begin
            model_acs(sym, fs, r);
            sb.push_back(r);
            mdl_ov = 1'b1;
        end else if (ordy) begin
            mdl_ov = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        check("out_valid", 64'(out_valid), 64'(mdl_ov));
        if (mdl_ov && sb.size() > 0) compare_front();
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        in_valid    = 1'b1;
        rx_sym      = 2'b11;
        frame_start = 1'b0;
        out_ready   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        mdl_ov   = 1'b0;
        sb.delete();
        mdl_pm[0] = 0;
        ref_u[0]  = 0;
        for (int n = 1; n < 4; n++) begin
            mdl_pm[n] = INIT_PM;
            ref_u[n]  = INIT_PM;
        end
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_pm0", 64'(pm0), 64'(0));
        check("rst_pm1", 64'(pm1), 64'(INIT_PM));
        check("rst_pm2", 64'(pm2), 64'(INIT_PM));
        check("rst_pm3", 64'(pm3), 64'(INIT_PM));
        check("rst_surv", 64'(surv), 64'(0));
        check("rst_best", 64'(best_state), 64'(0));
        check("rst_norm", 64'(norm), 64'(0));
    endtask

    initial begin
        int norm_seen;
        int ov_run;
        n_checks = 0;
        n_fails  = 0;
        mdl_ov   = 1'b0;

        // Reset state
        do_reset();

        // Frame start with received 00
        cycle(1'b1, 2'b00, 1'b1, 1'b1);
        check("s00_pm0", 64'(pm0), 64'(0));
        check("s00_pm1", 64'(pm1), 64'(33));
        check("s00_pm2", 64'(pm2), 64'(2));
        check("s00_pm3", 64'(pm3), 64'(33));
        check("s00_best", 64'(best_state), 64'(0));
        cycle(1'b0, 2'b00, 1'b0, 1'b1);

        // Frame start with received 11
        do_reset();
        cycle(1'b1, 2'b11, 1'b1, 1'b1);
        check("s11_pm0", 64'(pm0), 64'(2));
        check("s11_pm1", 64'(pm1), 64'(33));
        check("s11_pm2", 64'(pm2), 64'(0));
        check("s11_pm3", 64'(pm3), 64'(33));
        check("s11_surv", 64'(surv), 64'(0));
        check("s11_best", 64'(best_state), 64'(2));

        // Backpressure: pending symbol held off for 5 cycles, then accepted
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 2'b01, 1'b0, 1'b0);
            check("bp_pm2_hold", 64'(pm2), 64'(0));
        end
        cycle(1'b1, 2'b01, 1'b0, 1'b1);
        // Idle input, result held until consumed
        cycle(1'b0, 2'b10, 1'b0, 1'b0);
        cycle(1'b0, 2'b10, 1'b0, 1'b0);
        cycle(1'b0, 2'b00, 1'b0, 1'b1);

        // Long random stream: normalization against the unbounded reference
        norm_seen = 0;
        for (int i = 0; i < 600; i++) begin
            cycle(1'b1, 2'($urandom_range(3)), (i == 0), 1'b1);
            for (int n = 1; n < 4; n++) begin
                longint dd;
                longint du;
                case (n)
                    1:       dd = longint'(pm1) - longint'(pm0);
                    2:       dd = longint'(pm2) - longint'(pm0);
                    default: dd = longint'(pm3) - longint'(pm0);
                endcase
                du = ref_u[n] - ref_u[0];
                check("pm_diff", 64'(dd), 64'(du));
            end
            if (out_valid === 1'b1 && norm === 1'b1) norm_seen++;
        end
        check("norm_pulsed", 64'(norm_seen > 0), 64'(1));

        // Back-to-back streaming with no output gaps
        ov_run = 0;
        for (int i = 0; i < 64; i++) begin
            cycle(1'b1, 2'($urandom_range(3)), (i == 0), 1'b1);
            if (out_valid === 1'b1) ov_run++;
        end
        check("b2b_run", 64'(ov_run), 64'(64));

        // Reset in the middle of streaming, then restart a frame
        do_reset();
        for (int i = 0; i < 8; i++)
            cycle(1'b1, 2'($urandom_range(3)), (i == 0), 1'b1);
        cycle(1'b0, 2'b00, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
